// File: rtl/haraka_sponge_ctrl.sv
// Sponge controller for the Haraka-S hash path: absorbs padded rate blocks, sequences an
// external permutation core and squeezes an arbitrary-length digest as a byte stream.
module haraka_sponge_ctrl #(
  parameter int STATE_W = 512,
  parameter int RATE_W  = 256,
  parameter int LEN_W   = 64
) (
  input  logic               internal_clk,
  input  logic               reset,
  input  logic [RATE_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic [LEN_W-1:0]   digest_bytes,
  output logic [STATE_W-1:0] perm_in,
  output logic               perm_start,
  input  logic [STATE_W-1:0] perm_out,
  input  logic               perm_done,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);

  localparam int CAP_W      = STATE_W - RATE_W;
  localparam int RATE_BYTES = RATE_W / 8;
  localparam int IDX_W      = (RATE_BYTES > 1) ? $clog2(RATE_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATE_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    AB_START,
    AB_WAIT,
    SQ_OUT,
    SQ_START,
    SQ_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [STATE_W-1:0] perm_in_q, perm_in_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;

  // Shifting the rate left by idx bytes puts the selected byte at the top (byte 0 = MSB).
  logic [RATE_W-1:0]  rate_shift;
  logic [7:0]         out_byte;

  assign rate_shift = s_q[STATE_W-1 -: RATE_W] << {idx_q, 3'b000};
  assign out_byte   = rate_shift[RATE_W-1 -: 8];
  assign perm_in    = perm_in_q;

  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      perm_in_q <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      perm_in_q <= perm_in_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    perm_in_d  = perm_in_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    last_d     = last_q;
    in_ready   = 1'b0;
    busy       = 1'b1;
    perm_start = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          perm_in_d = {s_q[STATE_W-1 -: RATE_W] ^ in_data, s_q[CAP_W-1:0]};
          if (in_last) begin
            rem_d  = digest_bytes;
            last_d = 1'b1;
          end
          state_d = AB_START;
        end
      end

      AB_START: begin
        perm_start = 1'b1;
        state_d    = AB_WAIT;
      end

      AB_WAIT: begin
        if (perm_done) begin
          s_d = perm_out;
          if (!last_q) begin
            state_d = IDLE;
          end else if (rem_q == '0) begin
            // Zero-length digest: message finished, nothing to squeeze.
            s_d     = '0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = '0;
            state_d = SQ_OUT;
          end
        end
      end

      SQ_OUT: begin
        out_valid = 1'b1;
        out_data  = out_byte;
        out_last  = (rem_q == LEN_W'(1));
        if (out_ready) begin
          rem_d = rem_q - LEN_W'(1);
          idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
          if (rem_q == LEN_W'(1)) begin
            s_d     = '0;
            last_d  = 1'b0;
            idx_d   = '0;
            state_d = IDLE;
          end else if (idx_q == IDX_MAX) begin
            perm_in_d = s_q;
            state_d   = SQ_START;
          end
        end
      end

      SQ_START: begin
        perm_start = 1'b1;
        state_d    = SQ_WAIT;
      end

      SQ_WAIT: begin
        if (perm_done) begin
          s_d     = perm_out;
          idx_d   = '0;
          state_d = SQ_OUT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_haraka_sponge_ctrl.sv
// Self-checking bench for haraka_sponge_ctrl: a rotate/XOR permutation stand-in with fixed latency
// plus a plain sponge reference model that predicts absorb inputs, digest bytes and permutation counts.
module tb_haraka_sponge_ctrl;

  localparam int STATE_W = 512;
  localparam int RATE_W  = 256;
  localparam int LEN_W   = 64;
  localparam int RB      = RATE_W / 8;

  logic               internal_clk;
  logic               reset;
  logic [RATE_W-1:0]  in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [LEN_W-1:0]   digest_bytes;
  logic [STATE_W-1:0] perm_in;
  logic               perm_start;
  logic [STATE_W-1:0] perm_out;
  logic               perm_done;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  logic [STATE_W-1:0] ref_s;

  haraka_sponge_ctrl #(.STATE_W(STATE_W), .RATE_W(RATE_W), .LEN_W(LEN_W)) dut (
    .internal_clk(internal_clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .digest_bytes(digest_bytes),
    .perm_in(perm_in),
    .perm_start(perm_start),
    .perm_out(perm_out),
    .perm_done(perm_done),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy)
  );

  initial internal_clk = 1'b0;
  always #5 internal_clk = ~internal_clk;

  function automatic logic [STATE_W-1:0] perm_f(input logic [STATE_W-1:0] x);
    return {x[STATE_W-9:0], x[STATE_W-1 -: 8]} ^ STATE_W'(1);
  endfunction

  // Permutation core stand-in: captures perm_in on a start pulse, answers a few cycles later.
  initial begin
    logic [STATE_W-1:0] captured;
    perm_done = 1'b0;
    perm_out  = '0;
    forever begin
      @(negedge internal_clk);
      if (perm_start === 1'b1) begin
        captured = perm_in;
        repeat (2) @(negedge internal_clk);
        perm_out  = perm_f(captured);
        perm_done = 1'b1;
        @(negedge internal_clk);
        perm_done = 1'b0;
      end
    end
  end

  always @(negedge internal_clk) begin
    if (perm_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [STATE_W-1:0] obs,
                             input logic [STATE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one block, then checks the start pulse and the absorbed permutation input.
  task automatic applyStimulus(input logic [RATE_W-1:0] blk, input logic last,
                               input logic [LEN_W-1:0] dbytes);
    int guard;
    logic [STATE_W-1:0] exp_pin;
    guard = 0;
    @(negedge internal_clk);
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge internal_clk);
      guard++;
    end
    if (guard >= 200) checkOutput("in_ready_wait", STATE_W'(in_ready), STATE_W'(1));
    in_valid     = 1'b1;
    in_data      = blk;
    in_last      = last;
    digest_bytes = dbytes;
    exp_pin      = {ref_s[STATE_W-1 -: RATE_W] ^ blk, ref_s[STATE_W-RATE_W-1:0]};
    @(negedge internal_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("perm_start_after_accept", STATE_W'(perm_start), STATE_W'(1));
    checkOutput("perm_in_absorb", perm_in, exp_pin);
    ref_s = perm_f(exp_pin);
  endtask

  task automatic collectDigest(input int n, input bit rnd);
    logic [7:0] exp_q[$];
    logic [STATE_W-1:0] st;
    int idx;
    int guard;
    bit r;
    st = ref_s;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (i % RB) == 0) st = perm_f(st);
      exp_q.push_back(st[STATE_W-1-8*(i%RB) -: 8]);
    end
    idx = 0;
    guard = 0;
    while (idx < n && guard < 3000) begin
      @(negedge internal_clk);
      guard++;
      if (out_valid === 1'b1) begin
        checkOutput("out_data", STATE_W'(out_data), STATE_W'(exp_q[idx]));
        checkOutput("out_last", STATE_W'(out_last), STATE_W'(idx == n - 1));
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = r;
        if (r) idx++;
      end
    end
    if (idx < n) checkOutput("digest_timeout", STATE_W'(idx), STATE_W'(n));
    @(negedge internal_clk);
    out_ready = 1'b0;
    checkOutput("in_ready_after_last", STATE_W'(in_ready), STATE_W'(1));
    checkOutput("out_valid_after_last", STATE_W'(out_valid), STATE_W'(0));
    ref_s = '0;
  endtask

  function automatic logic [RATE_W-1:0] rand_block();
    logic [RATE_W-1:0] b;
    for (int i = 0; i < RATE_W / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    int base;
    int guard;
    reset        = 1'b1;
    in_data      = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    digest_bytes = '0;
    out_ready    = 1'b0;
    ref_s        = '0;

    repeat (2) @(negedge internal_clk);
    checkOutput("rst_in_ready", STATE_W'(in_ready), STATE_W'(1));
    checkOutput("rst_busy", STATE_W'(busy), STATE_W'(0));
    checkOutput("rst_perm_start", STATE_W'(perm_start), STATE_W'(0));
    checkOutput("rst_perm_in", perm_in, STATE_W'(0));
    checkOutput("rst_out_valid", STATE_W'(out_valid), STATE_W'(0));
    checkOutput("rst_out_last", STATE_W'(out_last), STATE_W'(0));
    checkOutput("rst_out_data", STATE_W'(out_data), STATE_W'(0));
    reset = 1'b0;

    $display("[TB] single block, 32 bytes");
    base = start_cnt;
    applyStimulus(RATE_W'(1), 1'b1, LEN_W'(32));
    collectDigest(32, 1'b0);
    checkOutput("starts_single", STATE_W'(start_cnt - base), STATE_W'(1));

    $display("[TB] two blocks, 32 bytes");
    base = start_cnt;
    applyStimulus(rand_block(), 1'b0, LEN_W'(0));
    applyStimulus(rand_block(), 1'b1, LEN_W'(32));
    collectDigest(32, 1'b0);
    checkOutput("starts_two_blocks", STATE_W'(start_cnt - base), STATE_W'(2));

    $display("[TB] single block, 40 bytes");
    base = start_cnt;
    applyStimulus(rand_block(), 1'b1, LEN_W'(40));
    collectDigest(40, 1'b0);
    checkOutput("starts_40", STATE_W'(start_cnt - base), STATE_W'(2));

    $display("[TB] zero-length digest");
    base = start_cnt;
    applyStimulus(rand_block(), 1'b1, LEN_W'(0));
    @(negedge internal_clk);
    checkOutput("d0_busy_wait1", STATE_W'(busy), STATE_W'(1));
    checkOutput("d0_no_valid1", STATE_W'(out_valid), STATE_W'(0));
    @(negedge internal_clk);
    checkOutput("d0_busy_wait2", STATE_W'(busy), STATE_W'(1));
    @(negedge internal_clk);
    checkOutput("d0_busy_drop", STATE_W'(busy), STATE_W'(0));
    checkOutput("d0_no_valid3", STATE_W'(out_valid), STATE_W'(0));
    checkOutput("starts_d0", STATE_W'(start_cnt - base), STATE_W'(1));
    ref_s = '0;
    base = start_cnt;
    applyStimulus(RATE_W'(1), 1'b1, LEN_W'(32));
    collectDigest(32, 1'b0);
    checkOutput("starts_after_d0", STATE_W'(start_cnt - base), STATE_W'(1));

    $display("[TB] random backpressure, 70 bytes");
    base = start_cnt;
    applyStimulus(rand_block(), 1'b1, LEN_W'(70));
    collectDigest(70, 1'b1);
    checkOutput("starts_70", STATE_W'(start_cnt - base), STATE_W'(3));

    $display("[TB] reset during squeeze permutation");
    applyStimulus(rand_block(), 1'b1, LEN_W'(40));
    out_ready = 1'b1;
    guard = 0;
    @(negedge internal_clk);
    while (perm_start !== 1'b1 && guard < 200) begin
      @(negedge internal_clk);
      guard++;
    end
    if (guard >= 200) checkOutput("sq_start_wait", STATE_W'(perm_start), STATE_W'(1));
    @(negedge internal_clk);
    reset = 1'b1;
    out_ready = 1'b0;
    #1;
    checkOutput("abort_busy", STATE_W'(busy), STATE_W'(0));
    checkOutput("abort_in_ready", STATE_W'(in_ready), STATE_W'(1));
    checkOutput("abort_perm_in", perm_in, STATE_W'(0));
    checkOutput("abort_out_valid", STATE_W'(out_valid), STATE_W'(0));
    checkOutput("abort_out_data", STATE_W'(out_data), STATE_W'(0));
    @(negedge internal_clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge internal_clk);
      checkOutput("post_abort_out_valid", STATE_W'(out_valid), STATE_W'(0));
      checkOutput("post_abort_busy", STATE_W'(busy), STATE_W'(0));
      checkOutput("post_abort_perm_start", STATE_W'(perm_start), STATE_W'(0));
    end
    ref_s = '0;
    base = start_cnt;
    applyStimulus(rand_block(), 1'b1, LEN_W'(33));
    collectDigest(33, 1'b0);
    checkOutput("starts_after_abort", STATE_W'(start_cnt - base), STATE_W'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
